// File: rtl/ysyx_22040750_trap_ctrl.sv
// Trap/CSR sequencer at MEM/WB: executes Zicsr ops in place and walks ecall, mret and
// timer-interrupt entry through the CSR file before redirecting the PC.
module ysyx_22040750_trap_ctrl #(
   parameter int unsigned         XLEN        = 64,
   parameter int unsigned         PC_W        = 32,
   parameter logic [XLEN-1:0]     ECALL_CAUSE = 64'd11,
   parameter logic [XLEN-1:0]     TIMER_CAUSE = 64'h8000_0000_0000_0007
) (
   input  logic            I_sys_clk,
   input  logic            I_rst_n,
   input  logic            I_valid,
   output logic            O_ready,
   input  logic [1:0]      I_csr_op,
   input  logic            I_ecall,
   input  logic            I_mret,
   input  logic            I_src_zero,
   input  logic [XLEN-1:0] I_src_data,
   input  logic [11:0]     I_csr_addr,
   input  logic [PC_W-1:0] I_pc,
   input  logic [PC_W-1:0] I_next_pc,
   input  logic            I_timer_irq,
   input  logic            I_mstatus_mie,
   input  logic            I_pipe_empty,
   input  logic [XLEN-1:0] I_csr_rd_data,
   output logic            O_csr_wen,
   output logic            O_csr_intr_wr,
   output logic            O_csr_intr_rd,
   output logic            O_csr_mret_wr,
   output logic            O_csr_mret_rd,
   output logic [11:0]     O_rd_addr,
   output logic [11:0]     O_wr_addr,
   output logic [XLEN-1:0] O_wr_data,
   output logic [PC_W-1:0] O_intr_pc,
   output logic [XLEN-1:0] O_intr_no,
   output logic [XLEN-1:0] O_rd_wb_data,
   output logic            O_stall,
   output logic            O_flush,
   output logic            O_redirect_valid,
   output logic [PC_W-1:0] O_redirect_pc
);

   typedef enum logic [2:0] {StIdle, StDrain, StTrap, StMret, StRedir} state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] target_q, target_d;
   logic [XLEN-1:0] cause_q, cause_d;

   logic            idle, csr_fire;
   logic [XLEN-1:0] csr_wdata;

   assign idle     = (state_q == StIdle);
   // ecall/mret outrank a CSR op carried by the same instruction
   assign csr_fire = idle && I_valid && !I_ecall && !I_mret && (I_csr_op != 2'b00);

   always_comb begin
      csr_wdata = I_src_data;
      case (I_csr_op)
         2'b10:   csr_wdata = I_csr_rd_data | I_src_data;
         2'b11:   csr_wdata = I_csr_rd_data & ~I_src_data;
         default: csr_wdata = I_src_data;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      target_d = target_q;
      cause_d  = cause_q;
      case (state_q)
         StIdle: begin
            if (I_valid && I_ecall) begin
               pc_d    = I_pc;
               cause_d = ECALL_CAUSE;
               state_d = StTrap;
            end else if (I_valid && I_mret) begin
               state_d = StMret;
            end else if (I_valid && (I_csr_op != 2'b00)) begin
               state_d = StIdle;
            end else if (I_timer_irq && I_mstatus_mie) begin
               cause_d = TIMER_CAUSE;
               state_d = StDrain;
            end
         end
         StDrain: begin
            pc_d = I_next_pc;
            if (I_pipe_empty) state_d = StTrap;
         end
         StTrap: begin
            target_d = {I_csr_rd_data[PC_W-1:2], 2'b00};
            state_d  = StRedir;
         end
         StMret: begin
            target_d = I_csr_rd_data[PC_W-1:0];
            state_d  = StRedir;
         end
         StRedir: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q  <= StIdle;
         pc_q     <= '0;
         target_q <= '0;
         cause_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         target_q <= target_d;
         cause_q  <= cause_d;
      end
   end

   always_comb begin
      O_ready          = idle;
      O_csr_wen        = csr_fire && !(I_src_zero && (I_csr_op != 2'b01));
      O_rd_addr        = csr_fire ? I_csr_addr : '0;
      O_wr_addr        = csr_fire ? I_csr_addr : '0;
      O_wr_data        = csr_fire ? csr_wdata : '0;
      O_rd_wb_data     = csr_fire ? I_csr_rd_data : '0;
      O_csr_intr_wr    = (state_q == StTrap);
      O_csr_intr_rd    = (state_q == StTrap);
      O_intr_pc        = (state_q == StTrap) ? pc_q : '0;
      O_intr_no        = (state_q == StTrap) ? cause_q : '0;
      O_csr_mret_wr    = (state_q == StMret);
      O_csr_mret_rd    = (state_q == StMret);
      O_stall          = !idle;
      O_flush          = (state_q == StRedir);
      O_redirect_valid = (state_q == StRedir);
      O_redirect_pc    = (state_q == StRedir) ? target_q : '0;
   end

endmodule

// File: tb/tb_ysyx_22040750_trap_ctrl.sv
// Self-checking bench for ysyx_22040750_trap_ctrl with a tiny CSR-file model on the read port.
module tb_ysyx_22040750_trap_ctrl;

   localparam logic [63:0] ECALL_NO = 64'd11;
   localparam logic [63:0] TIMER_NO = 64'h8000_0000_0000_0007;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid, ready, ecall, mret, src_zero, timer_irq, mie, pipe_empty;
   logic [1:0]  csr_op;
   logic [63:0] src_data, csr_rd_data, wr_data, intr_no, rd_wb_data;
   logic [11:0] csr_addr, rd_addr, wr_addr;
   logic [31:0] pc, next_pc, intr_pc, redirect_pc;
   logic        csr_wen, intr_wr, intr_rd, mret_wr, mret_rd, stall, flush, redirect_valid;
   logic [63:0] mtvec, mepc, mscratch;

   int checks = 0;
   int errors = 0;

   typedef struct {logic wen; logic [63:0] wdata; logic [63:0] rdwb;} csr_exp_t;
   typedef struct {logic [31:0] pc; logic [63:0] no;} trap_exp_t;
   csr_exp_t    csr_q[$];
   trap_exp_t   trap_q[$];
   logic [31:0] redir_q[$];

   always #5 clk = ~clk;

   assign csr_rd_data = intr_rd ? mtvec : (mret_rd ? mepc : mscratch);

   ysyx_22040750_trap_ctrl dut (
      .I_sys_clk       (clk),
      .I_rst_n         (rst_n),
      .I_valid         (valid),
      .O_ready         (ready),
      .I_csr_op        (csr_op),
      .I_ecall         (ecall),
      .I_mret          (mret),
      .I_src_zero      (src_zero),
      .I_src_data      (src_data),
      .I_csr_addr      (csr_addr),
      .I_pc            (pc),
      .I_next_pc       (next_pc),
      .I_timer_irq     (timer_irq),
      .I_mstatus_mie   (mie),
      .I_pipe_empty    (pipe_empty),
      .I_csr_rd_data   (csr_rd_data),
      .O_csr_wen       (csr_wen),
      .O_csr_intr_wr   (intr_wr),
      .O_csr_intr_rd   (intr_rd),
      .O_csr_mret_wr   (mret_wr),
      .O_csr_mret_rd   (mret_rd),
      .O_rd_addr       (rd_addr),
      .O_wr_addr       (wr_addr),
      .O_wr_data       (wr_data),
      .O_intr_pc       (intr_pc),
      .O_intr_no       (intr_no),
      .O_rd_wb_data    (rd_wb_data),
      .O_stall         (stall),
      .O_flush         (flush),
      .O_redirect_valid(redirect_valid),
      .O_redirect_pc   (redirect_pc)
   );

   task automatic clear_inputs();
      valid = 0; ecall = 0; mret = 0; csr_op = 2'b00; src_zero = 0; src_data = '0;
      csr_addr = '0; pc = '0; next_pc = '0; timer_irq = 0; mie = 0; pipe_empty = 1;
   endtask

   task automatic test_reset();
      clear_inputs();
      mtvec = '0; mepc = '0; mscratch = 64'h0F;
      rst_n = 0;
      #12;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
      checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b/%b expected 0/0", redirect_valid, flush); end
      checks++; if ({csr_wen, intr_wr, mret_wr} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {csr_wen, intr_wr, mret_wr}); end
      @(negedge clk); rst_n = 1;
   endtask

   task automatic test_csr_ops();
      logic [1:0]  ops  [6] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b01};
      logic [63:0] srcs [6] = '{64'hF0, 64'h0F, 64'h55, 64'h03, 64'h00, 64'h00};
      logic        zeros[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic        wens [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [63:0] wds  [6] = '{64'hFF, 64'h00, 64'h55, 64'h0C, 64'h00, 64'h00};
      csr_exp_t e;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         valid = 1; csr_op = ops[i]; src_data = srcs[i]; src_zero = zeros[i]; csr_addr = 12'h340;
         csr_q.push_back('{wen: wens[i], wdata: wds[i], rdwb: 64'h0F});
         #1;
         e = csr_q.pop_front();
         checks++; if (csr_wen !== e.wen) begin errors++; $display("FAIL csr_wen[%0d]: got %b expected %b", i, csr_wen, e.wen); end
         if (e.wen) begin
            checks++; if (wr_data !== e.wdata) begin errors++; $display("FAIL csr_wdata[%0d]: got %h expected %h", i, wr_data, e.wdata); end
         end
         checks++; if (rd_wb_data !== e.rdwb) begin errors++; $display("FAIL csr_rdwb[%0d]: got %h expected %h", i, rd_wb_data, e.rdwb); end
         checks++; if (wr_addr !== 12'h340 || rd_addr !== 12'h340) begin errors++; $display("FAIL csr_addr[%0d]: got %h/%h expected 340", i, rd_addr, wr_addr); end
         checks++; if (ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL csr_idle[%0d]: got ready %b stall %b expected 1/0", i, ready, stall); end
      end
      @(posedge clk); #1; clear_inputs();
      #1;
      checks++; if (csr_wen !== 1'b0 || wr_data !== 64'h0) begin errors++; $display("FAIL csr_idle_out: got wen %b data %h expected 0/0", csr_wen, wr_data); end
   endtask

   task automatic test_ecall();
      trap_exp_t t;
      logic [31:0] r;
      @(posedge clk); #1;
      mtvec = 64'h8000_0103; valid = 1; ecall = 1; pc = 32'h8000_0010;
      trap_q.push_back('{pc: 32'h8000_0010, no: ECALL_NO});
      redir_q.push_back(32'h8000_0100);
      #1;
      checks++; if (intr_wr !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL ecall_accept: got intr_wr %b ready %b expected 0/1", intr_wr, ready); end
      @(posedge clk); #1; valid = 0; ecall = 0;
      #1;
      checks++; if (intr_wr !== 1'b1 || intr_rd !== 1'b1) begin errors++; $display("FAIL ecall_trap_strobe: got %b/%b expected 1/1", intr_wr, intr_rd); end
      checks++; if (stall !== 1'b1 || ready !== 1'b0 || csr_wen !== 1'b0) begin errors++; $display("FAIL ecall_trap_ctl: got stall %b ready %b wen %b expected 1/0/0", stall, ready, csr_wen); end
      if (intr_wr === 1'b1 && trap_q.size() > 0) begin
         t = trap_q.pop_front();
         checks++; if (intr_no !== t.no) begin errors++; $display("FAIL ecall_intr_no: got %h expected %h", intr_no, t.no); end
         checks++; if (intr_pc !== t.pc) begin errors++; $display("FAIL ecall_intr_pc: got %h expected %h", intr_pc, t.pc); end
      end
      @(posedge clk); #2;
      checks++; if (redirect_valid !== 1'b1 || flush !== 1'b1 || intr_wr !== 1'b0) begin errors++; $display("FAIL ecall_redir: got valid %b flush %b intr_wr %b expected 1/1/0", redirect_valid, flush, intr_wr); end
      if (redirect_valid === 1'b1 && redir_q.size() > 0) begin
         r = redir_q.pop_front();
         checks++; if (redirect_pc !== r) begin errors++; $display("FAIL ecall_redir_pc: got %h expected %h", redirect_pc, r); end
      end
      @(posedge clk); #2;
      checks++; if (ready !== 1'b1 || redirect_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL ecall_back_idle: got ready %b redir %b stall %b expected 1/0/0", ready, redirect_valid, stall); end
   endtask

   task automatic test_mret();
      int mret_cycles = 0;
      logic [31:0] r;
      @(posedge clk); #1;
      mepc = 64'h8000_0014; valid = 1; mret = 1;
      redir_q.push_back(32'h8000_0014);
      @(posedge clk); #1; valid = 0; mret = 0;
      #1;
      checks++; if (mret_wr !== 1'b1 || mret_rd !== 1'b1 || intr_wr !== 1'b0) begin errors++; $display("FAIL mret_strobe: got wr %b rd %b intr %b expected 1/1/0", mret_wr, mret_rd, intr_wr); end
      for (int i = 0; i < 3; i++) begin
         if (mret_wr === 1'b1) mret_cycles++;
         if (redirect_valid === 1'b1 && redir_q.size() > 0) begin
            r = redir_q.pop_front();
            checks++; if (redirect_pc !== r) begin errors++; $display("FAIL mret_redir_pc: got %h expected %h", redirect_pc, r); end
         end
         @(posedge clk); #2;
      end
      checks++; if (mret_cycles != 1) begin errors++; $display("FAIL mret_once: got %0d cycles expected 1", mret_cycles); end
   endtask

   task automatic test_timer_irq();
      trap_exp_t t;
      logic [31:0] r;
      @(posedge clk); #1;
      mtvec = 64'h8000_0201; timer_irq = 1; mie = 1; pipe_empty = 0; next_pc = 32'h8000_0020;
      trap_q.push_back('{pc: 32'h8000_0040, no: TIMER_NO});
      redir_q.push_back(32'h8000_0200);
      #1;
      checks++; if (ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL irq_accept: got ready %b stall %b expected 1/0", ready, stall); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         next_pc = 32'h8000_0024 + 32'(4 * i);
         if (i == 1) timer_irq = 0;
         #1;
         checks++; if (stall !== 1'b1 || ready !== 1'b0 || intr_wr !== 1'b0) begin errors++; $display("FAIL irq_drain[%0d]: got stall %b ready %b intr %b expected 1/0/0", i, stall, ready, intr_wr); end
      end
      @(posedge clk); #1; pipe_empty = 1; next_pc = 32'h8000_0040;
      #1;
      checks++; if (stall !== 1'b1 || intr_wr !== 1'b0) begin errors++; $display("FAIL irq_drain_last: got stall %b intr %b expected 1/0", stall, intr_wr); end
      @(posedge clk); #1; next_pc = 32'h8000_0099;
      #1;
      checks++; if (intr_wr !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL irq_trap: got intr %b stall %b expected 1/1", intr_wr, stall); end
      if (intr_wr === 1'b1 && trap_q.size() > 0) begin
         t = trap_q.pop_front();
         checks++; if (intr_no !== t.no) begin errors++; $display("FAIL irq_intr_no: got %h expected %h", intr_no, t.no); end
         checks++; if (intr_pc !== t.pc) begin errors++; $display("FAIL irq_intr_pc: got %h expected %h", intr_pc, t.pc); end
      end
      @(posedge clk); #2;
      checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL irq_redir: got %b expected 1", redirect_valid); end
      if (redirect_valid === 1'b1 && redir_q.size() > 0) begin
         r = redir_q.pop_front();
         checks++; if (redirect_pc !== r) begin errors++; $display("FAIL irq_redir_pc: got %h expected %h", redirect_pc, r); end
      end
      @(posedge clk); #1; clear_inputs();
      timer_irq = 1; mie = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #2;
         checks++; if (stall !== 1'b0 || intr_wr !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL irq_masked[%0d]: got stall %b intr %b ready %b expected 0/0/1", i, stall, intr_wr, ready); end
      end
      timer_irq = 0;
   endtask

   task automatic test_back_to_back();
      trap_exp_t t;
      logic [31:0] r;
      @(posedge clk); #1;
      mtvec = 64'h8000_0300; valid = 1; ecall = 1; pc = 32'h8000_0050;
      timer_irq = 1; mie = 1; pipe_empty = 1; next_pc = 32'h8000_0060;
      trap_q.push_back('{pc: 32'h8000_0050, no: ECALL_NO});
      redir_q.push_back(32'h8000_0300);
      trap_q.push_back('{pc: 32'h8000_0060, no: TIMER_NO});
      redir_q.push_back(32'h8000_0300);
      for (int ev = 0; ev < 2; ev++) begin
         @(posedge clk); #1; valid = 0; ecall = 0;
         if (ev == 1) begin
            timer_irq = 0;
            #1;
            checks++; if (stall !== 1'b1 || intr_wr !== 1'b0) begin errors++; $display("FAIL b2b_drain: got stall %b intr %b expected 1/0", stall, intr_wr); end
            @(posedge clk); #1;
         end
         #1;
         checks++; if (intr_wr !== 1'b1) begin errors++; $display("FAIL b2b_trap[%0d]: got %b expected 1", ev, intr_wr); end
         if (intr_wr === 1'b1 && trap_q.size() > 0) begin
            t = trap_q.pop_front();
            checks++; if (intr_no !== t.no) begin errors++; $display("FAIL b2b_intr_no[%0d]: got %h expected %h", ev, intr_no, t.no); end
            checks++; if (intr_pc !== t.pc) begin errors++; $display("FAIL b2b_intr_pc[%0d]: got %h expected %h", ev, intr_pc, t.pc); end
         end
         @(posedge clk); #2;
         if (redirect_valid === 1'b1 && redir_q.size() > 0) begin
            r = redir_q.pop_front();
            checks++; if (redirect_pc !== r) begin errors++; $display("FAIL b2b_redir_pc[%0d]: got %h expected %h", ev, redirect_pc, r); end
         end else begin
            checks++; errors++; $display("FAIL b2b_redir[%0d]: got valid %b expected 1", ev, redirect_valid);
         end
         @(posedge clk); #2;
         checks++; if (ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d]: got ready %b stall %b expected 1/0", ev, ready, stall); end
      end
   endtask

   task automatic test_reset_abort();
      int bad;
      for (int sc = 0; sc < 2; sc++) begin
         @(posedge clk); #1;
         if (sc == 0) begin
            timer_irq = 1; mie = 1; pipe_empty = 0;
         end else begin
            valid = 1; ecall = 1; pc = 32'h8000_0070;
         end
         @(posedge clk); #1;
         clear_inputs();
         pipe_empty = 0;
         #1;
         checks++; if (stall !== 1'b1) begin errors++; $display("FAIL abort_pre[%0d]: got stall %b expected 1", sc, stall); end
         rst_n = 0;
         #1;
         checks++; if (ready !== 1'b1 || stall !== 1'b0 || {csr_wen, intr_wr, mret_wr} !== 3'b000) begin errors++; $display("FAIL abort_now[%0d]: got ready %b stall %b strobes %b expected 1/0/000", sc, ready, stall, {csr_wen, intr_wr, mret_wr}); end
         @(negedge clk); rst_n = 1;
         bad = 0;
         for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            if (redirect_valid !== 1'b0 || intr_wr !== 1'b0 || flush !== 1'b0 || ready !== 1'b1) bad++;
         end
         checks++; if (bad != 0) begin errors++; $display("FAIL abort_after[%0d]: got %0d active cycles expected 0", sc, bad); end
      end
   endtask

   initial begin
      test_reset();
      test_csr_ops();
      test_ecall();
      test_mret();
      test_timer_irq();
      test_back_to_back();
      test_reset_abort();
      checks++;
      if (trap_q.size() != 0 || redir_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d trap and %0d redirect left expected 0/0", trap_q.size(), redir_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
